// File: rtl/dma_axi_rd_if.sv
// dma_axi_rd_if
// AXI4 read-side interface of the DMA. Burst requests from the streamer are
// issued on the AR channel. R beats land in a local FIFO and are replayed to
// the streamer as a valid/ready stream. FIFO space is reserved per burst
// before its AR goes out, so the R channel never sees back-pressure in legal
// operation.

module dma_axi_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTSTD = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]            req_alen_i,
    input  logic [2:0]            req_size_i,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    input  logic                  err_clr_i,
    output logic                  err_o,
    output logic                  cfg_err_o,
    output logic                  idle_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTD + 1);

    logic                  ar_valid;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;

    logic [OW-1:0]         outstd;
    logic [CW-1:0]         reserved;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];

    logic [8:0]            need_beats;
    logic [31:0]           need32;
    logic [31:0]           used32;
    logic                  oversize;
    logic                  fits;
    logic                  slot_free;
    logic                  req_hs;
    logic                  accept;
    logic                  cfg_set;
    logic                  r_hs;
    logic                  last_hs;
    logic                  pop;
    logic                  err_set;
    logic [CW-1:0]         res_add;
    logic [CW-1:0]         res_sub;

    // Request admission: one AR in the holding register at a time, bounded
    // outstanding bursts, and enough unreserved FIFO space for the whole burst.
    // Oversize bursts can never fit, so they are swallowed and flagged instead.
    always_comb begin
        need_beats  = {1'b0, req_alen_i} + 9'd1;
        need32      = 32'(need_beats);
        used32      = 32'(fifo_count) + 32'(reserved);
        oversize    = need32 > 32'(FIFO_DEPTH);
        fits        = (used32 + need32) <= 32'(FIFO_DEPTH);
        slot_free   = 32'(outstd) < 32'(MAX_OUTSTD);
        req_ready_o = !ar_valid && (oversize || (slot_free && fits));
        req_hs      = req_valid_i && req_ready_o;
        accept      = req_hs && !oversize;
        cfg_set     = req_hs && oversize;
        r_hs        = axi_rvalid_i && axi_rready_o;
        last_hs     = r_hs && axi_rlast_i;
        pop         = rd_valid_o && rd_ready_i;
        err_set     = r_hs && ((axi_rresp_i != 2'b00) || (outstd == '0));
        res_add     = accept ? CW'(need_beats) : '0;
        res_sub     = (r_hs && (reserved != '0)) ? CW'(1) : '0;
    end

    // AR holding register: load on an accepted request, clear once the slave takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid <= 1'b0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
        end else if (accept) begin
            ar_valid <= 1'b1;
            ar_addr  <= req_addr_i;
            ar_len   <= req_alen_i;
            ar_size  <= req_size_i;
        end else if (ar_valid && axi_arready_i) begin
            ar_valid <= 1'b0;
        end
    end

    // Outstanding-burst and reserved-beat bookkeeping; neither may underflow
    // even if the slave sends beats nobody asked for.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstd   <= '0;
            reserved <= '0;
        end else begin
            case ({accept, last_hs && (outstd != '0)})
                2'b10:   outstd <= outstd + OW'(1);
                2'b01:   outstd <= outstd - OW'(1);
                default: outstd <= outstd;
            endcase
            reserved <= reserved + res_add - res_sub;
        end
    end

    // Read-data FIFO pointers and occupancy; each entry is {rdata, rlast}.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (r_hs) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({r_hs, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (r_hs) begin
            mem[wr_ptr] <= {axi_rdata_i, axi_rlast_i};
        end
    end

    // Sticky error flags; a new error in the clear cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o     <= 1'b0;
            cfg_err_o <= 1'b0;
        end else begin
            if (err_set) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
            if (cfg_set) begin
                cfg_err_o <= 1'b1;
            end else if (err_clr_i) begin
                cfg_err_o <= 1'b0;
            end
        end
    end

    // Output drive: AR from the holding register, stream from the FIFO head.
    always_comb begin
        axi_arvalid_o = ar_valid;
        axi_araddr_o  = ar_addr;
        axi_arlen_o   = ar_len;
        axi_arsize_o  = ar_size;
        axi_arburst_o = 2'b01;
        axi_rready_o  = fifo_count != CW'(FIFO_DEPTH);
        rd_valid_o    = fifo_count != '0;
        rd_data_o     = rd_valid_o ? mem[rd_ptr][DATA_WIDTH:1] : '0;
        rd_last_o     = rd_valid_o ? mem[rd_ptr][0] : 1'b0;
        idle_o        = !ar_valid && (outstd == '0) && (fifo_count == '0);
    end

endmodule

// File: tb/tb_dma_axi_rd_if.sv
// tb_dma_axi_rd_if
// Directed bench for dma_axi_rd_if with default parameters
// (32-bit address/data, 4 outstanding bursts, 16-entry FIFO).

module tb_dma_axi_rd_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [7:0]  req_alen_i;
    logic [2:0]  req_size_i;
    logic        axi_arvalid_o;
    logic        axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [7:0]  axi_arlen_o;
    logic [2:0]  axi_arsize_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i;
    logic        axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic        axi_rlast_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_data_o;
    logic        rd_last_o;
    logic        err_clr_i;
    logic        err_o;
    logic        cfg_err_o;
    logic        idle_o;

    int n_assert = 0;
    int n_fail   = 0;

    dma_axi_rd_if dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_alen_i    (req_alen_i),
        .req_size_i    (req_size_i),
        .axi_arvalid_o (axi_arvalid_o),
        .axi_arready_i (axi_arready_i),
        .axi_araddr_o  (axi_araddr_o),
        .axi_arlen_o   (axi_arlen_o),
        .axi_arsize_o  (axi_arsize_o),
        .axi_arburst_o (axi_arburst_o),
        .axi_rvalid_i  (axi_rvalid_i),
        .axi_rready_o  (axi_rready_o),
        .axi_rdata_i   (axi_rdata_i),
        .axi_rresp_i   (axi_rresp_i),
        .axi_rlast_i   (axi_rlast_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_data_o     (rd_data_o),
        .rd_last_o     (rd_last_o),
        .err_clr_i     (err_clr_i),
        .err_o         (err_o),
        .cfg_err_o     (cfg_err_o),
        .idle_o        (idle_o)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    // Drive the request channel.
    task automatic applyStimulus(input logic v, input logic [31:0] addr,
                                 input logic [7:0] alen, input logic [2:0] size);
        req_valid_i = v;
        req_addr_i  = addr;
        req_alen_i  = alen;
        req_size_i  = size;
    endtask

    // Drive one R-channel beat (or idle the channel when v is 0).
    task automatic driveBeat(input logic v, input logic [31:0] data,
                             input logic [1:0] resp, input logic last);
        axi_rvalid_i = v;
        axi_rdata_i  = data;
        axi_rresp_i  = resp;
        axi_rlast_i  = last;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reset with all inputs quiet.
    task automatic doReset();
        rst           = 1'b1;
        applyStimulus(1'b0, 32'h0, 8'h0, 3'h0);
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        axi_arready_i = 1'b0;
        rd_ready_i    = 1'b0;
        err_clr_i     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        int acc;
        int ars;
        logic rready_low;
        logic ready_seen;

        $display("[TB] start");

        // Reset values
        doReset();
        settle();
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd1);
        checkOutput("rst_arvalid",   64'(axi_arvalid_o), 64'd0);
        checkOutput("rst_arburst",   64'(axi_arburst_o), 64'd1);
        checkOutput("rst_rready",    64'(axi_rready_o), 64'd1);
        checkOutput("rst_idle",      64'(idle_o), 64'd1);
        checkOutput("rst_rd_valid",  64'(rd_valid_o), 64'd0);
        checkOutput("rst_rd_data",   64'(rd_data_o), 64'd0);
        checkOutput("rst_err",       64'(err_o), 64'd0);
        checkOutput("rst_cfg_err",   64'(cfg_err_o), 64'd0);

        // Single burst: addr 0x1000, alen 3, size 2
        axi_arready_i = 1'b1;
        applyStimulus(1'b1, 32'h1000, 8'd3, 3'd2);
        settle();
        checkOutput("t1_req_ready", 64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        settle();
        checkOutput("t1_arvalid", 64'(axi_arvalid_o), 64'd1);
        checkOutput("t1_araddr",  64'(axi_araddr_o), 64'h1000);
        checkOutput("t1_arlen",   64'(axi_arlen_o), 64'd3);
        checkOutput("t1_arsize",  64'(axi_arsize_o), 64'd2);
        checkOutput("t1_arburst", 64'(axi_arburst_o), 64'd1);
        checkOutput("t1_req_busy", 64'(req_ready_o), 64'd0);
        tick();
        checkOutput("t1_ar_done", 64'(axi_arvalid_o), 64'd0);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            driveBeat(1'b1, 32'hA0 + 32'(i), 2'b00, i == 3);
            tick();
            checkOutput("t1_rd_valid", 64'(rd_valid_o), 64'd1);
            checkOutput("t1_rd_data",  64'(rd_data_o), 64'hA0 + 64'(i));
            checkOutput("t1_rd_last",  64'(rd_last_o), (i == 3) ? 64'd1 : 64'd0);
        end
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        tick();
        checkOutput("t1_drained", 64'(rd_valid_o), 64'd0);
        checkOutput("t1_idle",    64'(idle_o), 64'd1);
        checkOutput("t1_err",     64'(err_o), 64'd0);

        // Outstanding limit: five single-beat requests, no R traffic
        doReset();
        axi_arready_i = 1'b1;
        applyStimulus(1'b1, 32'h2000, 8'd0, 3'd2);
        acc = 0;
        ars = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (req_valid_i && req_ready_o) acc++;
            if (axi_arvalid_o && axi_arready_i) ars++;
            tick();
        end
        settle();
        checkOutput("t2_accepts", 64'(acc), 64'd4);
        checkOutput("t2_ars",     64'(ars), 64'd4);
        checkOutput("t2_blocked", 64'(req_ready_o), 64'd0);
        driveBeat(1'b1, 32'h55, 2'b00, 1'b1);
        settle();
        checkOutput("t2_blocked_rbeat", 64'(req_ready_o), 64'd0);
        tick();
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        settle();
        checkOutput("t2_reopen", 64'(req_ready_o), 64'd1);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);

        // Reservation: two 8-beat bursts fill the 16-entry budget
        doReset();
        axi_arready_i = 1'b1;
        applyStimulus(1'b1, 32'h3000, 8'd7, 3'd2);
        settle();
        checkOutput("t3_req1", 64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 32'h3020, 8'd7, 3'd2);
        settle();
        checkOutput("t3_req2", 64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        tick();
        applyStimulus(1'b1, 32'h3040, 8'd0, 3'd2);
        settle();
        checkOutput("t3_refuse", 64'(req_ready_o), 64'd0);
        rready_low = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            driveBeat(1'b1, 32'h100 + 32'(i), 2'b00, (i == 7) || (i == 15));
            settle();
            if (!axi_rready_o) rready_low = 1'b1;
            if (req_ready_o) ready_seen = 1'b1;
            tick();
        end
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        settle();
        checkOutput("t3_rready_held",   64'(rready_low), 64'd0);
        checkOutput("t3_refused_during", 64'(ready_seen), 64'd0);
        checkOutput("t3_refuse_full",   64'(req_ready_o), 64'd0);
        checkOutput("t3_head_valid",    64'(rd_valid_o), 64'd1);
        checkOutput("t3_head_data",     64'(rd_data_o), 64'h100);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        settle();
        checkOutput("t3_after_pop", 64'(req_ready_o), 64'd1);
        checkOutput("t3_next_data", 64'(rd_data_o), 64'h101);
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);

        // Oversize request: alen 16 on a 16-entry FIFO
        doReset();
        axi_arready_i = 1'b1;
        applyStimulus(1'b1, 32'h4000, 8'd16, 3'd2);
        settle();
        checkOutput("t4_ready", 64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        settle();
        checkOutput("t4_cfg_err", 64'(cfg_err_o), 64'd1);
        checkOutput("t4_no_ar",   64'(axi_arvalid_o), 64'd0);
        checkOutput("t4_idle",    64'(idle_o), 64'd1);
        tick();
        checkOutput("t4_no_ar_late", 64'(axi_arvalid_o), 64'd0);
        checkOutput("t4_cfg_hold",   64'(cfg_err_o), 64'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        settle();
        checkOutput("t4_cfg_clr", 64'(cfg_err_o), 64'd0);

        // SLVERR on beat 2 of 4, then an unexpected beat
        doReset();
        axi_arready_i = 1'b1;
        rd_ready_i    = 1'b1;
        applyStimulus(1'b1, 32'h5000, 8'd3, 3'd2);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            driveBeat(1'b1, 32'hB0 + 32'(i), (i == 1) ? 2'b10 : 2'b00, i == 3);
            tick();
            checkOutput("t5_rd_data", 64'(rd_data_o), 64'hB0 + 64'(i));
            checkOutput("t5_err",     64'(err_o), (i >= 1) ? 64'd1 : 64'd0);
        end
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        tick();
        tick();
        checkOutput("t5_err_sticky", 64'(err_o), 64'd1);
        checkOutput("t5_drained",    64'(rd_valid_o), 64'd0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        settle();
        checkOutput("t5_err_clr", 64'(err_o), 64'd0);
        rd_ready_i = 1'b0;
        driveBeat(1'b1, 32'hC0, 2'b00, 1'b1);
        tick();
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        settle();
        checkOutput("t5_err_unexp",  64'(err_o), 64'd1);
        checkOutput("t5_unexp_kept", 64'(rd_data_o), 64'hC0);
        err_clr_i = 1'b1;
        driveBeat(1'b1, 32'hC1, 2'b10, 1'b1);
        tick();
        err_clr_i = 1'b0;
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        settle();
        checkOutput("t5_set_wins", 64'(err_o), 64'd1);

        // Reset in the middle of a burst with three beats buffered
        doReset();
        axi_arready_i = 1'b1;
        applyStimulus(1'b1, 32'h6000, 8'd7, 3'd2);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            driveBeat(1'b1, 32'hD0 + 32'(i), (i == 2) ? 2'b10 : 2'b00, 1'b0);
            tick();
        end
        driveBeat(1'b0, 32'h0, 2'b00, 1'b0);
        axi_arready_i = 1'b0;
        applyStimulus(1'b1, 32'h7000, 8'd0, 3'd2);
        settle();
        checkOutput("t6_pre_valid", 64'(rd_valid_o), 64'd1);
        checkOutput("t6_pre_err",   64'(err_o), 64'd1);
        checkOutput("t6_req2",      64'(req_ready_o), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 8'd0, 3'd0);
        settle();
        checkOutput("t6_ar_pending", 64'(axi_arvalid_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checkOutput("t6_rd_valid", 64'(rd_valid_o), 64'd0);
        checkOutput("t6_arvalid",  64'(axi_arvalid_o), 64'd0);
        checkOutput("t6_idle",     64'(idle_o), 64'd1);
        checkOutput("t6_err",      64'(err_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
